i2c_master_burst: RTL and testbench

Parametrised I2C master, the successor to the single-byte write master.
- Adds a programmable SCL rate, multi-byte write and read bursts, and ACK sampling from the real SDA line.
- Adds NACK abort and a TX-data stall handshake.
- Sits between a register/control block and the open-drain pad cells for SCL and SDA.

---
 rtl/i2c_master_burst.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_burst.sv
// I2C burst master: START, address, N-byte write/read, STOP.
// Optional slave clock stretching is compiled in with I2C_CLOCK_STRETCH_EN.
module i2c_master_burst #(
    parameter int CLK_DIV = 250,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl_m,
    output logic             sda_m_oe,
    input  logic             sda_m_in,
    input  logic             scl_m_in
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_LOAD,
        S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             rw_q, rw_d;
    logic             ack_q, ack_d;
    logic             nack_q, nack_d;
    logic [7:0]       rx_q, rx_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ready_q, tx_ready_d;
    logic             done_q, done_d;

    logic scl_c, oe_c, bit_hi, stretch, qtick, sample, bit_end;

    assign bit_hi = (qtr_q == 2'd1) || (qtr_q == 2'd2);

`ifdef I2C_CLOCK_STRETCH_EN
    assign stretch = (state_q != S_IDLE) && (qtr_q == 2'd1)
                     && scl_c && !scl_m_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_m_in;
    assign stretch = 1'b0;
`endif

    assign qtick   = (cnt_q == CNT_MAX) && !stretch;
    assign sample  = qtick && (qtr_q == 2'd1);
    assign bit_end = qtick && (qtr_q == 2'd3);

    // Pad drive decoded from state and quarter.
    always_comb begin
        scl_c = 1'b1;
        oe_c  = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_START: begin
                scl_c = (qtr_q < 2'd2);
                oe_c  = (qtr_q != 2'd0);
            end
            S_ADDR, S_WR_BYTE: begin
                scl_c = bit_hi;
                oe_c  = ~sh_q[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: scl_c = bit_hi;
            S_RD_ACK: begin
                scl_c = bit_hi;
                oe_c  = (rem_q > LEN_ONE);
            end
            S_LOAD: scl_c = 1'b0;
            S_STOP: begin
                scl_c = (qtr_q != 2'd0);
                oe_c  = (qtr_q < 2'd2);
            end
            default: ;
        endcase
    end

    // Quarter timing, next state and datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rem_d      = rem_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        nack_d     = nack_q;
        rx_d       = rx_q;
        rx_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        done_d     = 1'b0;

        if (state_q != S_IDLE && state_q != S_LOAD) begin
            if (!stretch) cnt_d = qtick ? '0 : cnt_q + CW'(1);
            if (qtick) qtr_d = qtr_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE: if (run) begin
                state_d = S_START;
                sh_d    = {addr, rw};
                rw_d    = rw;
                rem_d   = (len > LEN_MAX) ? LEN_MAX : len;
                nack_d  = 1'b0;
                cnt_d   = '0;
                qtr_d   = 2'd0;
            end
            S_START: if (bit_end) begin
                state_d = S_ADDR;
                bit_d   = 3'd0;
            end
            S_ADDR, S_WR_BYTE: if (bit_end) begin
                sh_d  = {sh_q[6:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7)
                    state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
            end
            S_ADDR_ACK: begin
                if (sample) begin
                    ack_d = sda_m_in;
                    if (sda_m_in) nack_d = 1'b1;
                end
                if (bit_end) begin
                    bit_d = 3'd0;
                    if (ack_q || rem_q == '0) state_d = S_STOP;
                    else if (!rw_q) state_d = S_LOAD;
                    else state_d = S_RD_BYTE;
                end
            end
            S_LOAD: if (tx_valid) begin
                sh_d       = tx_data;
                tx_ready_d = 1'b1;
                bit_d      = 3'd0;
                state_d    = S_WR_BYTE;
            end
            S_WR_ACK: begin
                if (sample) begin
                    ack_d = sda_m_in;
                    if (sda_m_in) nack_d = 1'b1;
                end
                if (bit_end) begin
                    if (ack_q) begin
                        state_d = S_STOP;
                    end else begin
                        if (rem_q != '0) rem_d = rem_q - LEN_ONE;
                        state_d = (rem_q <= LEN_ONE) ? S_STOP : S_LOAD;
                    end
                end
            end
            S_RD_BYTE: begin
                if (sample) begin
                    sh_d = {sh_q[6:0], sda_m_in};
                    if (bit_q == 3'd7) begin
                        rx_d       = {sh_q[6:0], sda_m_in};
                        rx_valid_d = 1'b1;
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_RD_ACK;
                end
            end
            S_RD_ACK: if (bit_end) begin
                if (rem_q != '0) rem_d = rem_q - LEN_ONE;
                bit_d   = 3'd0;
                state_d = (rem_q <= LEN_ONE) ? S_STOP : S_RD_BYTE;
            end
            S_STOP: if (bit_end) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            sh_q       <= 8'd0;
            rem_q      <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            rx_q       <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rem_q      <= rem_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            done_q     <= done_d;
        end
    end

    assign scl_m    = scl_c;
    assign sda_m_oe = oe_c;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign nack     = nack_q;
    assign rx_data  = rx_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: behavioural slave, scoreboard of bus
// frames, received bytes and end-of-transfer status.
module tb_i2c_master_burst;

    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run = 1'b0;
    logic [6:0]       addr = '0;
    logic             rw = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready, rx_valid, busy, done, nack;
    logic [7:0]       rx_data;
    logic             scl_m, sda_m_oe, sda_m_in, scl_m_in;
    logic             sl_oe = 1'b0;
    logic             hold_scl = 1'b0;

    assign sda_m_in = ~(sda_m_oe | sl_oe);
    assign scl_m_in = scl_m & ~hold_scl;

    i2c_master_burst #(
        .CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .addr(addr), .rw(rw),
        .len(len), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .done(done), .nack(nack), .scl_m(scl_m),
        .sda_m_oe(sda_m_oe), .sda_m_in(sda_m_in), .scl_m_in(scl_m_in)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp_frame_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] txq[$];
    int         exp_nack_q[$];
    int         exp_ntx_q[$];
    logic [7:0] pat[16];
    logic [7:0] rd_mem[16];

    bit cfg_ack_addr = 1'b1;
    int cfg_nack_at = 99;
    int cfg_rd_len = 0;
    bit slave_rst = 1'b0;
    int frames_seen = 0;
    int ntx = 0;
    bit stall_en = 1'b0;
    int gate_cnt = 0;
    int max_low = 0;
    int low_run = 0;

    function automatic void check(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void fail(string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event with no expectation or timeout", nm);
    endfunction

    // Behavioural I2C slave: decodes START/STOP, records 9-bit frames
    // (8 data bits plus ACK level) and drives ACK / read data on SCL fall.
    initial begin : slave
        logic p_scl, p_sda, s_scl, s_sda;
        logic [8:0] frame;
        bit active, rdm;
        int bitn, nbyte;
        p_scl = 1'b1; p_sda = 1'b1; frame = '0;
        active = 0; rdm = 0; bitn = 0; nbyte = 0;
        forever begin
            @(negedge clk);
            s_scl = scl_m;
            s_sda = sda_m_in;
            if (slave_rst) begin
                active = 0; sl_oe = 1'b0; bitn = 0; slave_rst = 1'b0;
            end else if (p_scl && s_scl && p_sda && !s_sda) begin
                active = 1; bitn = 0; nbyte = 0; sl_oe = 1'b0;
            end else if (p_scl && s_scl && !p_sda && s_sda) begin
                active = 0; sl_oe = 1'b0;
            end else if (active && !p_scl && s_scl) begin
                frame = {frame[7:0], s_sda};
                bitn++;
                if (bitn == 9) begin
                    obs_q.push_back(frame);
                    if (nbyte == 0) rdm = frame[1];
                    nbyte++;
                    bitn = 0;
                    frames_seen++;
                end
            end else if (active && p_scl && !s_scl) begin
                if (bitn == 8) begin
                    if (nbyte == 0) sl_oe = cfg_ack_addr;
                    else if (!rdm) sl_oe = (nbyte - 1 != cfg_nack_at);
                    else sl_oe = 1'b0;
                end else if (rdm && nbyte >= 1 && nbyte - 1 < cfg_rd_len) begin
                    sl_oe = ~rd_mem[nbyte-1][7-bitn];
                end else begin
                    sl_oe = 1'b0;
                end
            end
            p_scl = s_scl;
            p_sda = sda_m_in;
        end
    end

    // TX source: presents the queue head, pops on tx_ready,
    // optionally withholds the second byte.
    initial begin : tx_src
        bit blk;
        forever begin
            @(negedge clk);
            if (tx_ready) begin
                ntx++;
                if (txq.size() > 0) void'(txq.pop_front());
            end
            if (stall_en && ntx == 1 && frames_seen >= 2 && gate_cnt < 50)
                gate_cnt++;
            blk = stall_en && ntx == 1 && gate_cnt < 50;
            tx_valid = (txq.size() > 0) && !blk;
            tx_data = (txq.size() > 0) ? txq[0] : 8'h00;
        end
    end

    // Monitor: pops expectations whenever the DUT shows an output.
    initial begin : monitor
        logic [8:0] f;
        forever begin
            @(negedge clk);
            if (!scl_m) low_run++;
            else low_run = 0;
            if (low_run > max_low) max_low = low_run;
            while (obs_q.size() > 0) begin
                f = obs_q.pop_front();
                if (exp_frame_q.size() == 0) fail("frame_extra");
                else check("frame", int'(f), int'(exp_frame_q.pop_front()));
            end
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) fail("rx_extra");
                else check("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
            end
            if (done) begin
                if (exp_nack_q.size() == 0) begin
                    fail("done_extra");
                end else begin
                    check("nack", int'(nack), exp_nack_q.pop_front());
                    check("tx_ready_cnt", ntx, exp_ntx_q.pop_front());
                    check("frames_left", exp_frame_q.size(), 0);
                end
            end
        end
    end

    task automatic xfer(input logic [6:0] a, input bit r, input int l,
                        input bit aa, input int na, input bit st,
                        input bit rnd, output int cyc);
        int cl;
        int nt;
        int t;
        bit en;
        logic [7:0] b;
        cl = (l > MAX_LEN) ? MAX_LEN : l;
        nt = 0;
        en = !aa;
        cfg_ack_addr = aa;
        cfg_nack_at = na;
        cfg_rd_len = (aa && r) ? cl : 0;
        stall_en = st;
        gate_cnt = 0;
        ntx = 0;
        frames_seen = 0;
        max_low = 0;
        exp_frame_q.push_back({a, r, !aa});
        if (aa) begin
            for (int i = 0; i < cl; i++) begin
                b = rnd ? 8'($urandom) : pat[i];
                if (!r) begin
                    txq.push_back(b);
                    nt++;
                    exp_frame_q.push_back({b, i == na});
                    if (i == na) begin
                        en = 1'b1;
                        break;
                    end
                end else begin
                    rd_mem[i] = b;
                    exp_frame_q.push_back({b, i == cl - 1});
                    exp_rx_q.push_back(b);
                end
            end
        end
        exp_nack_q.push_back(int'(en));
        exp_ntx_q.push_back(nt);
        @(negedge clk);
        addr = a; rw = r; len = LEN_W'(l); run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("busy_after_run", int'(busy), 1);
        check("nack_cleared", int'(nack), 0);
        t = 1;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        cyc = t;
        if (!done) begin
            fail("done_timeout");
        end else begin
            check("busy_at_done", int'(busy), 0);
            @(negedge clk);
            check("done_single", int'(done), 0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int cyc, cyc2, rises, t;
        logic ps;
        repeat (3) @(negedge clk);
        check("rst_scl", int'(scl_m), 1);
        check("rst_sda_oe", int'(sda_m_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_nack", int'(nack), 0);
        check("rst_tx_ready", int'(tx_ready), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        pat[0] = 8'hA5; pat[1] = 8'h3C;
        xfer(7'h50, 1'b0, 2, 1'b1, 99, 1'b0, 1'b0, cyc);
        xfer(7'h21, 1'b0, 1, 1'b0, 99, 1'b0, 1'b1, cyc);
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
        xfer(7'h68, 1'b1, 3, 1'b1, 99, 1'b0, 1'b0, cyc);
        xfer(7'h2A, 1'b0, 3, 1'b1, 99, 1'b1, 1'b1, cyc);
        check("stall_scl_low_ge40", int'(max_low >= 40), 1);
        xfer(7'h3B, 1'b0, 0, 1'b1, 99, 1'b0, 1'b1, cyc);
        xfer(7'h44, 1'b0, 20, 1'b1, 99, 1'b0, 1'b1, cyc);
        xfer(7'h45, 1'b1, 17, 1'b1, 99, 1'b0, 1'b1, cyc);
        xfer(7'h46, 1'b0, 4, 1'b1, 1, 1'b0, 1'b1, cyc);
        for (int k = 0; k < 8; k++) begin
            xfer(7'($urandom), 1'($urandom), $urandom_range(0, 18),
                 ($urandom % 5) != 0,
                 (($urandom % 3) == 0) ? $urandom_range(0, 3) : 99,
                 1'b0, 1'b1, cyc);
        end

        addr = 7'h5A; rw = 1'b0; len = LEN_W'(1); run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        rises = 0; t = 0; ps = scl_m;
        while (rises < 3 && t < 2000) begin
            @(negedge clk);
            t++;
            if (!ps && scl_m) rises++;
            ps = scl_m;
        end
        if (rises < 3) fail("reset_wait_timeout");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        slave_rst = 1'b1;
        #1;
        check("midrst_scl", int'(scl_m), 1);
        check("midrst_sda_oe", int'(sda_m_oe), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        xfer(7'h5A, 1'b0, 0, 1'b1, 99, 1'b0, 1'b1, cyc);

`ifdef I2C_CLOCK_STRETCH_EN
        xfer(7'h33, 1'b0, 0, 1'b1, 99, 1'b0, 1'b1, cyc);
        fork
            begin
                int r9, tt;
                logic pp;
                r9 = 0; tt = 0; pp = scl_m;
                while (r9 < 9 && tt < 3000) begin
                    @(negedge clk);
                    tt++;
                    if (!pp && scl_m) r9++;
                    pp = scl_m;
                end
                hold_scl = 1'b1;
                repeat (30) @(negedge clk);
                hold_scl = 1'b0;
            end
        join_none
        xfer(7'h33, 1'b0, 0, 1'b1, 99, 1'b0, 1'b1, cyc2);
        check("stretch_extra_clocks", cyc2 - cyc, 30);
`endif

        check("leftover_expect",
              exp_frame_q.size() + exp_rx_q.size() + exp_nack_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
